// File: rtl/carregador_instrucoes.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words,
// writes them to consecutive word addresses and holds the CPU while loading.
module carregador_instrucoes #(
    parameter int PALAVRAS_MAX = 32,
    parameter int LARG_ENDR    = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inicia,
    input  logic [5:0]           num_palavras,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 we_instr,
    output logic [LARG_ENDR-1:0] endr_instr,
    output logic [31:0]          din_instr,
    output logic                 segura_cpu,
    output logic                 pronto,
    output logic [7:0]           checksum,
    output logic [1:0]           estado_dbg
);

    // Handshake: a byte transfers on a rising edge where byte_valid and byte_ready are both high;
    // the source must hold byte_in stable while byte_valid is high and byte_ready is low.

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        RECEBE    = 2'd1,
        ESCREVE   = 2'd2,
        CONCLUIDO = 2'd3
    } estado_t;

    localparam logic [5:0] MAX_PAL = 6'(PALAVRAS_MAX);

    estado_t              estado_q, estado_d;
    logic [5:0]           total_q, total_d;
    logic [5:0]           palavra_q, palavra_d;
    logic [1:0]           cnt_byte_q, cnt_byte_d;
    logic [31:0]          shift_q, shift_d;
    logic [7:0]           checksum_q, checksum_d;
    logic [LARG_ENDR-1:0] endr_q, endr_d;
    logic [31:0]          din_q, din_d;
    logic [5:0]           total_pedido;

    assign total_pedido = (num_palavras > MAX_PAL) ? MAX_PAL : num_palavras;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= OCIOSO;
            total_q    <= '0;
            palavra_q  <= '0;
            cnt_byte_q <= '0;
            shift_q    <= '0;
            checksum_q <= '0;
            endr_q     <= '0;
            din_q      <= '0;
        end else begin
            estado_q   <= estado_d;
            total_q    <= total_d;
            palavra_q  <= palavra_d;
            cnt_byte_q <= cnt_byte_d;
            shift_q    <= shift_d;
            checksum_q <= checksum_d;
            endr_q     <= endr_d;
            din_q      <= din_d;
        end
    end

    always_comb begin
        estado_d   = estado_q;
        total_d    = total_q;
        palavra_d  = palavra_q;
        cnt_byte_d = cnt_byte_q;
        shift_d    = shift_q;
        checksum_d = checksum_q;
        endr_d     = endr_q;
        din_d      = din_q;
        case (estado_q)
            OCIOSO, CONCLUIDO: begin
                if (inicia) begin
                    total_d    = total_pedido;
                    palavra_d  = '0;
                    cnt_byte_d = '0;
                    checksum_d = '0;
                    estado_d   = (total_pedido == 6'd0) ? CONCLUIDO : RECEBE;
                end
            end
            RECEBE: begin
                if (byte_valid) begin
                    shift_d[{cnt_byte_q, 3'b000} +: 8] = byte_in;
                    checksum_d = checksum_q + byte_in;
                    cnt_byte_d = cnt_byte_q + 2'd1;
                    if (cnt_byte_q == 2'd3) begin
                        // Capture the write address/data now so they hold after the counter advances.
                        endr_d   = palavra_q[LARG_ENDR-1:0];
                        din_d    = {byte_in, shift_q[23:0]};
                        estado_d = ESCREVE;
                    end
                end
            end
            ESCREVE: begin
                palavra_d  = palavra_q + 6'd1;
                cnt_byte_d = '0;
                estado_d   = ((palavra_q + 6'd1) == total_q) ? CONCLUIDO : RECEBE;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    assign byte_ready = (estado_q == RECEBE);
    assign we_instr   = (estado_q == ESCREVE);
    assign segura_cpu = (estado_q == RECEBE) || (estado_q == ESCREVE);
    assign pronto     = (estado_q == CONCLUIDO);
    assign endr_instr = endr_q;
    assign din_instr  = din_q;
    assign checksum   = checksum_q;
    assign estado_dbg = estado_q;

endmodule
